// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter: one byte per tx_send pulse, LSB first, registered tx line.
// tx_busy combines the frame-in-flight flag with the live request so a pulse is never seen as idle.
module uart_tx_byte #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_send,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             busy;
    logic             busy_next;
    logic             tx_reg;
    logic             tx_next;
    logic             done_reg;
    logic             done_next;
    logic             baud_last;

    assign baud_last = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            busy     <= 1'b0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            busy     <= busy_next;
            tx_reg   <= tx_next;
            done_reg <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        busy_next     = busy;
        done_next     = 1'b0;
        tx_next       = 1'b1;

        case (state)
            IDLE: begin
                if (tx_send) begin
                    shift_next    = tx_data;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    busy_next     = 1'b1;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    shift_next    = {1'b0, shift[7:1]};
                    bit_idx_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    busy_next     = 1'b0;
                    done_next     = 1'b1;
                    state_next    = IDLE;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // tx is registered, so it is decoded from where the FSM is heading next
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx_busy = busy | tx_send;
    assign tx_done = done_reg;
    assign tx      = tx_reg;

endmodule
